clz_normalize_arbiter: RTL and testbench
========================================

Name: clz_normalize_arbiter

Overview:
- Shares one leading-zero-count + normalize-shift datapath among NUM_REQ requesters, e.g. the per-lane FP/int-to-float normalization clients in the SIMT core.
- Round-robin arbitration, two-stage pipeline, valid/ready on both sides.
- Full backpressure with no data loss.
- Adds zero-operand detection: the bare count tree reports W-1 for an all-zero input, which is ambiguous with an input of 1.

Parameters:
- NUM_REQ, 4, number of requesters; power of 2, >=2.
- W, 32, operand width; power of 2, >=2.
- TAG_W, 4, opaque per-request tag width, returned unchanged.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  request valid, one bit per requester.
- req_ready  output  NUM_REQ  request accepted this cycle, one bit per requester.
- req_data  input  NUM_REQ*W  operands; requester i at [i*W +: W].
- req_tag  input  NUM_REQ*TAG_W  tags; requester i at [i*TAG_W +: TAG_W].
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  $clog2(NUM_REQ)  index of the originating requester.
- rsp_tag  output  TAG_W  tag of the originating request.
- rsp_count  output  $clog2(W)+1  leading-zero count, 0..W.
- rsp_norm  output  W  operand shifted left by rsp_count; 0 if operand is 0.
- rsp_zero  output  1  operand was all zeros.
- busy  output  1  either pipeline stage holds a valid entry.

Behaviour:
- Reset (async assert, sync deassert use): s1_valid=0, s2_valid=0, rsp_valid=0, busy=0, req_ready=0, rr_ptr=NUM_REQ-1 (requester 0 has first priority). Data/tag/id registers are don't-care.
- Stage 1 (arbitrate/capture):
  - Combinational round-robin grant: first i with req_valid[i]=1, searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - s1_en = !s1_valid || s1_adv.
  - req_ready[i] = grant[i] && s1_en. At most one bit is set; it is 0 when no request is valid.
  - On handshake (req_valid[i] && req_ready[i]): capture data, tag and id=i; s1_valid<=1; rr_ptr<=i.
  - rr_ptr is unchanged when no handshake occurs.
  - If s1_adv is true and there is no handshake: s1_valid<=0.
- Stage 2 (compute/output):
  - s1_adv = s1_valid && (!s2_valid || rsp_ready).
  - On s1_adv, register from the s1 operand:
    - cnt = leading-zero count (tree method, log2(W) levels).
    - zero = (operand==0).
    - rsp_count = zero ? W : cnt.
    - rsp_norm = operand << cnt, or 0 if zero.
    - rsp_id and rsp_tag carried through.
  - s2_valid<=1 on s1_adv.
  - If rsp_ready && s2_valid && !s1_adv: s2_valid<=0.
- Outputs:
  - rsp_valid = s2_valid.
  - rsp_* are stable while rsp_valid && !rsp_ready.
  - busy = s1_valid | s2_valid.
- Latency and throughput:
  - Handshake in cycle N gives rsp_valid in cycle N+2 when there is no backpressure.
  - Sustained throughput is 1 result per cycle.
- Ordering: responses leave in acceptance order. At most 2 requests are in flight.
- Handshake rules:
  - req_ready may depend combinationally on req_valid and rsp_ready.
  - Requesters must hold valid, data and tag stable until ready.
  - Requesters must not gate valid on ready.
  - A requester that drops valid before ready is simply not granted; no error is raised.
- Simultaneous events:
  - rsp_ready and a new request in the same cycle with both stages full: both stages advance; no bubble.
  - A single requester re-requesting every cycle while others are idle: granted every cycle.
  - With all requesting, a requester waits at most NUM_REQ-1 grants.
- Reset mid-operation: in-flight entries are discarded with no response. The first post-reset grant goes to the lowest valid index.
- Width rule: rsp_count needs $clog2(W)+1 bits to represent W. The shift amount into the normalizer uses the low $clog2(W) bits.

Test Plan:
- Reset, then req 2 sends 0x0000_0F00, tag 5 -> 2 cycles later: rsp_id=2, tag=5, count=20, norm=0xF000_0000, zero=0.
- Boundary operands on req 0: 0x8000_0000 -> count 0, norm 0x8000_0000. 0x0000_0001 -> count 31, norm 0x8000_0000. 0x0 -> count 32, norm 0, zero=1.
- All 4 requesters valid continuously, rsp_ready=1 -> grant/rsp_id sequence 0,1,2,3,0,1,... with one response per cycle after a 2-cycle fill.
- Requesters 1 and 3 valid, rsp_ready held low 6 cycles -> exactly 2 handshakes, then all req_ready=0. rsp fields are stable. On release: id 1, then id 3, then id 1, with no loss or duplication.
- Assert reset while both stages are full and rsp_valid=1 -> outputs go to 0 immediately (async). After deassert, requests from 2 and 3 -> req 2 is served first.
- Random valid/data/tag/backpressure for 10k cycles against a scoreboard model -> every accepted request gets exactly one correct response, in order, and no requester is starved.

Source files
------------

// File: rtl/clz_normalize_arbiter.sv
// clz_normalize_arbiter: round-robin shared two-stage leading-zero count and normalize unit
module clz_normalize_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 32,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*W-1:0]       req_data,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [$clog2(W):0]         rsp_count,
    output logic [W-1:0]               rsp_norm,
    output logic                       rsp_zero,
    output logic                       busy
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int SW  = $clog2(W);

    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d, gnt_id, s1_id_q, s2_id_q;
    logic             gnt_any, s1_en, s1_adv, hs, zero, s2_zero_q;
    logic [W-1:0]     s1_data_q, s2_norm_q, shifted;
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
    logic [SW-1:0]    cnt;
    logic [SW:0]      s2_count_q;

    // Descending scan so the nearest requester after rr_ptr wins; rr_ptr itself is last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = rr_ptr_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[rr_ptr_q + IDW'(k)]) begin
                gnt_any = 1'b1;
                gnt_id  = rr_ptr_q + IDW'(k);
            end
        end
    end

    assign s1_adv     = s1_valid_q && (!s2_valid_q || rsp_ready);
    assign s1_en      = !s1_valid_q || s1_adv;
    assign hs         = gnt_any && s1_en && !reset;
    assign req_ready  = hs ? (NUM_REQ'(1) << gnt_id) : '0;
    assign s1_valid_d = hs || (s1_valid_q && !s1_adv);
    assign s2_valid_d = s1_adv || (s2_valid_q && !rsp_ready);
    assign rr_ptr_d   = hs ? gnt_id : rr_ptr_q;

    // Log2(W) levels: each level tests the top half-window and shifts it out when empty.
    always_comb begin
        shifted = s1_data_q;
        cnt     = '0;
        for (int l = SW - 1; l >= 0; l--) begin
            if ((shifted >> (W - (1 << l))) == '0) begin
                cnt[l]  = 1'b1;
                shifted = shifted << (1 << l);
            end
        end
    end

    assign zero = s1_data_q == '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            rr_ptr_q   <= IDW'(NUM_REQ - 1);
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            s1_data_q <= req_data[gnt_id*W +: W];
            s1_tag_q  <= req_tag[gnt_id*TAG_W +: TAG_W];
            s1_id_q   <= gnt_id;
        end
        if (s1_adv) begin
            s2_norm_q  <= zero ? '0 : shifted;
            s2_count_q <= zero ? (SW+1)'(W) : {1'b0, cnt};
            s2_zero_q  <= zero;
            s2_tag_q   <= s1_tag_q;
            s2_id_q    <= s1_id_q;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_tag   = s2_tag_q;
    assign rsp_count = s2_count_q;
    assign rsp_norm  = s2_norm_q;
    assign rsp_zero  = s2_zero_q;
    assign busy      = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_clz_normalize_arbiter.sv
// tb_clz_normalize_arbiter: directed scenarios plus a randomized queue-based scoreboard
module tb_clz_normalize_arbiter;
    localparam int N = 4, W = 32, TW = 4;

    logic          clk = 1'b0, reset = 1'b1, rsp_ready = 1'b0;
    logic [N-1:0]  req_valid = '0, req_ready;
    logic [N*W-1:0]  req_data = '0;
    logic [N*TW-1:0] req_tag = '0;
    logic          rsp_valid, rsp_zero, busy;
    logic [1:0]    rsp_id;
    logic [TW-1:0] rsp_tag;
    logic [5:0]    rsp_count;
    logic [W-1:0]  rsp_norm;
    int checks = 0, errors = 0;

    typedef struct {
        int          id;
        logic [3:0]  tag;
        logic [31:0] data;
        int          cyc;
    } ent_t;

    always #5 clk = ~clk;

    clz_normalize_arbiter #(.NUM_REQ(N), .W(W), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_count(rsp_count), .rsp_norm(rsp_norm),
        .rsp_zero(rsp_zero), .busy(busy)
    );

    function automatic int ref_clz(logic [31:0] d);
        int n = 0;
        while (n < 32 && d[31-n] == 1'b0) n++;
        return n;
    endfunction

    function automatic logic [31:0] ref_norm(logic [31:0] d);
        int n = ref_clz(d);
        return (n == 32) ? 32'h0 : d << n;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        tick;
        req_valid = '1; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        req_valid = '0;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        rsp_ready = 1'b1;
        req_data[2*W +: W] = 32'h0000_0F00; req_tag[2*TW +: TW] = 4'd5; req_valid = 4'b0100; #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL basic_ready got %b exp 0100", req_ready); end
        tick; req_valid = '0; #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_latency got v=%b busy=%b exp v=0 busy=1", rsp_valid, busy); end
        tick; #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_count, rsp_norm, rsp_zero} !== {1'b1, 2'd2, 4'd5, 6'd20, 32'hF000_0000, 1'b0}) begin
            errors++;
            $display("FAIL basic_rsp got v=%b id=%0d tag=%0d cnt=%0d norm=%h z=%b exp v=1 id=2 tag=5 cnt=20 norm=f0000000 z=0",
                     rsp_valid, rsp_id, rsp_tag, rsp_count, rsp_norm, rsp_zero);
        end
        tick; #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_drain got v=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_boundary;
        logic [31:0] ops [3] = '{32'h8000_0000, 32'h0000_0001, 32'h0};
        logic [31:0] en  [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0};
        logic [5:0]  ec  [3] = '{6'd0, 6'd31, 6'd32};
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_data[0 +: W] = ops[k]; req_tag[0 +: TW] = 4'(k); req_valid = 4'b0001;
            tick; req_valid = '0;
            tick; #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_count, rsp_norm, rsp_zero} !== {1'b1, 2'd0, ec[k], en[k], k == 2}) begin
                errors++;
                $display("FAIL boundary_%0d got v=%b id=%0d cnt=%0d norm=%h z=%b exp cnt=%0d norm=%h z=%b",
                         k, rsp_valid, rsp_id, rsp_count, rsp_norm, rsp_zero, ec[k], en[k], k == 2);
            end
            tick;
        end
    endtask

    task automatic test_round_robin;
        int id;
        do_reset;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = 32'h0001_0000 << i;
            req_tag[i*TW +: TW] = 4'(i + 8);
        end
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++; if (req_ready !== (N'(1) << (c % N))) begin errors++; $display("FAIL rr_grant_c%0d got %b exp %b", c, req_ready, N'(1) << (c % N)); end
            checks++; if (rsp_valid !== (c >= 2)) begin errors++; $display("FAIL rr_valid_c%0d got %b exp %b", c, rsp_valid, c >= 2); end
            if (c >= 2) begin
                id = (c - 2) % N;
                checks++;
                if ({rsp_id, rsp_tag, rsp_count} !== {2'(id), 4'(id + 8), 6'(15 - id)}) begin
                    errors++;
                    $display("FAIL rr_rsp_c%0d got id=%0d tag=%0d cnt=%0d exp id=%0d tag=%0d cnt=%0d",
                             c, rsp_id, rsp_tag, rsp_count, id, id + 8, 15 - id);
                end
            end
            tick;
        end
        req_valid = '0;
        tick; tick; tick; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", rsp_valid); end
    endtask

    task automatic test_backpressure;
        int hs = 0;
        logic [3:0] exp_rdy;
        logic [43:0] snap;
        rsp_ready = 1'b0;
        req_data[1*W +: W] = 32'h00F0_0000; req_tag[1*TW +: TW] = 4'd1;
        req_data[3*W +: W] = 32'h0000_0003; req_tag[3*TW +: TW] = 4'd3;
        req_valid = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_rdy = (c == 0) ? 4'b0010 : (c == 1) ? 4'b1000 : 4'b0000;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL bp_ready_c%0d got %b exp %b", c, req_ready, exp_rdy); end
            if ((req_ready & req_valid) != 0) hs++;
            if (c >= 2) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL bp_hold_c%0d got v=%b id=%0d exp v=1 id=1", c, rsp_valid, rsp_id); end
                if (c == 2) snap = {rsp_tag, rsp_count, rsp_norm, rsp_zero, rsp_id};
                else begin
                    checks++;
                    if ({rsp_tag, rsp_count, rsp_norm, rsp_zero, rsp_id} !== snap) begin
                        errors++; $display("FAIL bp_stable_c%0d got %h exp %h", c, {rsp_tag, rsp_count, rsp_norm, rsp_zero, rsp_id}, snap);
                    end
                end
            end
            tick;
            if (c == 0) req_tag[1*TW +: TW] = 4'd9;
            if (c == 1) req_tag[3*TW +: TW] = 4'd11;
        end
        checks++; if (hs !== 2) begin errors++; $display("FAIL bp_handshakes got %0d exp 2", hs); end
        rsp_ready = 1'b1; #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b exp 0010", req_ready); end
        checks++; if ({rsp_valid, rsp_id, rsp_tag, rsp_count} !== {1'b1, 2'd1, 4'd1, 6'd8}) begin errors++; $display("FAIL bp_rsp0 got v=%b id=%0d tag=%0d cnt=%0d exp 1 1 1 8", rsp_valid, rsp_id, rsp_tag, rsp_count); end
        tick; req_valid = '0; #1;
        checks++; if ({rsp_valid, rsp_id, rsp_tag, rsp_count} !== {1'b1, 2'd3, 4'd3, 6'd30}) begin errors++; $display("FAIL bp_rsp1 got v=%b id=%0d tag=%0d cnt=%0d exp 1 3 3 30", rsp_valid, rsp_id, rsp_tag, rsp_count); end
        tick; #1;
        checks++; if ({rsp_valid, rsp_id, rsp_tag} !== {1'b1, 2'd1, 4'd9}) begin errors++; $display("FAIL bp_rsp2 got v=%b id=%0d tag=%0d exp 1 1 9", rsp_valid, rsp_id, rsp_tag); end
        tick; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", rsp_valid); end
    endtask

    task automatic test_async_reset;
        rsp_ready = 1'b0; req_valid = '1;
        tick; tick; #1;
        checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ar_full got v=%b busy=%b exp 1 1", rsp_valid, busy); end
        reset = 1'b1; #1;
        checks++; if ({rsp_valid, busy, req_ready} !== 6'b0) begin errors++; $display("FAIL ar_async got v=%b busy=%b rdy=%b exp 0 0 0000", rsp_valid, busy, req_ready); end
        req_valid = '0;
        tick;
        reset = 1'b0; rsp_ready = 1'b1; req_valid = 4'b1100; #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ar_first_grant got %b exp 0100", req_ready); end
        tick; req_valid = 4'b1000; #1;
        checks++; if (req_ready !== 4'b1000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_second got rdy=%b v=%b exp 1000 0", req_ready, rsp_valid); end
        tick; req_valid = '0; #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL ar_rsp0 got v=%b id=%0d exp 1 2", rsp_valid, rsp_id); end
        tick; #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin errors++; $display("FAIL ar_rsp1 got v=%b id=%0d exp 1 3", rsp_valid, rsp_id); end
        tick; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_empty got %b exp 0", rsp_valid); end
    endtask

    task automatic test_random;
        ent_t q[$];
        ent_t e;
        int mptr = N - 1, g;
        int waits[N] = '{default: 0};
        logic [N-1:0] pend = '0, exp_rdy;
        logic exp_rv;
        do_reset;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rsp_ready = (cyc >= 9960) ? 1'b1 : ($urandom_range(0, 99) < (((cyc / 500) % 2) ? 30 : 90));
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && cyc < 9960 && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    req_data[i*W +: W] = $urandom >> $urandom_range(0, 32);
                    req_tag[i*TW +: TW] = 4'($urandom);
                end
            end
            req_valid = pend; #1;
            g = -1;
            for (int k = 1; k <= N; k++) if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
            exp_rdy = (g >= 0 && (q.size() < 2 || rsp_ready)) ? (N'(1) << g) : '0;
            exp_rv = q.size() > 0 && (cyc - q[0].cyc) >= 2;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, req_ready, exp_rdy); end
            checks++; if (rsp_valid !== exp_rv || busy !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got v=%b busy=%b exp v=%b busy=%b", cyc, rsp_valid, busy, exp_rv, q.size() > 0); end
            if (exp_rv) begin
                e = q[0];
                checks++;
                if ({rsp_id, rsp_tag, rsp_count, rsp_norm, rsp_zero} !== {2'(e.id), e.tag, 6'(ref_clz(e.data)), ref_norm(e.data), e.data == 0}) begin
                    errors++;
                    $display("FAIL rnd_rsp cyc=%0d got id=%0d tag=%0d cnt=%0d norm=%h z=%b exp id=%0d tag=%0d cnt=%0d norm=%h z=%b",
                             cyc, rsp_id, rsp_tag, rsp_count, rsp_norm, rsp_zero, e.id, e.tag, ref_clz(e.data), ref_norm(e.data), e.data == 0);
                end
                if (rsp_ready) void'(q.pop_front());
            end
            if (exp_rdy != 0) begin
                for (int j = 0; j < N; j++) if (j != g && pend[j]) waits[j]++;
                checks++; if (waits[g] > N - 1) begin errors++; $display("FAIL rnd_starve req=%0d got %0d grants waited exp <= %0d", g, waits[g], N - 1); end
                waits[g] = 0;
                mptr = g;
                e.id = g; e.tag = req_tag[g*TW +: TW]; e.data = req_data[g*W +: W]; e.cyc = cyc;
                q.push_back(e);
                pend[g] = 1'b0;
            end
            tick;
        end
        checks++; if (q.size() != 0 || pend != 0) begin errors++; $display("FAIL rnd_leftover got queue=%0d pend=%b exp 0 0000", q.size(), pend); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_boundary;
        test_round_robin;
        test_backpressure;
        test_async_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
